// File: rtl/mdio_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
// Shared definitions for the MDIO Clause 22 peripheral register file:
// FSM state encoding, opcode values, frame field lengths and the broadcast
// PHY address.
// -----------------------------------------------------------------------------
package mdio_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StOp    = 3'd2,
        StPhyad = 3'd3,
        StRegad = 3'd4,
        StTa    = 3'd5,
        StData  = 3'd6
    } mdio_state_e;

    localparam logic [1:0]  OP_READ      = 2'b10;
    localparam logic [1:0]  OP_WRITE     = 2'b01;

    localparam int unsigned PREAMBLE_LEN = 32;
    localparam int unsigned OP_LEN       = 2;
    localparam int unsigned ADDR_LEN     = 5;
    localparam int unsigned TA_LEN       = 2;
    localparam int unsigned DATA_LEN     = 16;

    localparam logic [4:0]  BCAST_ADDR   = 5'd0;

endpackage

// File: rtl/mdio_edge_sync.sv
// -----------------------------------------------------------------------------
// mdio_edge_sync
// Two-flop synchronisers for mdc and mdio plus mdc rising-edge detection.
// Ports:
//   i_clk, i_rst_n  : system clock, asynchronous active-low reset
//   i_mdc, i_mdio   : raw management clock and serial data from the pad
//   o_mdc_rise      : one-clk pulse per synchronised mdc rising edge
//   o_mdio_s        : synchronised mdio, aligned with o_mdc_rise
// -----------------------------------------------------------------------------
module mdio_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_mdc_rise,
    output logic o_mdio_s
);

    logic [1:0] r_mdc_sync;
    logic [1:0] r_mdio_sync;
    logic       r_mdc_prev;

    // Reset to 1 so an idle-high mdc does not look like a rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mdc_sync  <= 2'b11;
            r_mdio_sync <= 2'b11;
            r_mdc_prev  <= 1'b1;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[0], i_mdc};
            r_mdio_sync <= {r_mdio_sync[0], i_mdio};
            r_mdc_prev  <= r_mdc_sync[1];
        end
    end

    assign o_mdc_rise = r_mdc_sync[1] & ~r_mdc_prev;
    assign o_mdio_s   = r_mdio_sync[1];

endmodule

// File: rtl/mdio_peripheral_regfile.sv
// -----------------------------------------------------------------------------
// mdio_peripheral_regfile
// Clause 22 MDIO peripheral fronting a bank of 16-bit registers that are also
// writable from a local host port.
// Ports:
//   i_clk, i_rst_n           : system clock, asynchronous active-low reset
//   i_mdc, i_mdio_in         : management clock and serial data in (async)
//   o_mdio_out, o_mdio_oe    : serial data out and pad output enable
//   i_host_wr_en/addr/wdata  : host register write port
//   o_host_rdata             : combinational read of reg[i_host_addr]
//   o_wr_strobe              : one-clk pulse on MDIO write commit
//   o_rd_strobe              : one-clk pulse when a matched read enters TA
//   o_last_regad             : REGAD of the last accepted frame
// -----------------------------------------------------------------------------
module mdio_peripheral_regfile
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR          = 5'd1,
    parameter int         REG_COUNT         = 32,
    parameter bit         PREAMBLE_SUPPRESS = 1'b0,
    parameter bit         BCAST_EN          = 1'b0,
    localparam int        AW                = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_mdc,
    input  logic          i_mdio_in,
    output logic          o_mdio_out,
    output logic          o_mdio_oe,
    input  logic          i_host_wr_en,
    input  logic [AW-1:0] i_host_addr,
    input  logic [15:0]   i_host_wdata,
    output logic [15:0]   o_host_rdata,
    output logic          o_wr_strobe,
    output logic          o_rd_strobe,
    output logic [4:0]    o_last_regad
);

    localparam logic [5:0] PRE_FULL = 6'(PREAMBLE_LEN);

    logic        w_mdc_rise;
    logic        w_mdio_s;

    mdio_state_e r_state;
    logic [3:0]  r_cnt;
    logic [5:0]  r_pre_cnt;
    logic [15:0] r_shift;
    logic [1:0]  r_op;
    logic        r_match;
    logic [4:0]  r_regad;
    logic [4:0]  r_last_regad;
    logic        r_mdio_oe;
    logic        r_mdio_out;
    logic        r_wr_strobe;
    logic        r_rd_strobe;
    logic [15:0] r_regs [REG_COUNT];

    logic [1:0]  w_op;
    logic [4:0]  w_field5;
    logic        w_phy_match;
    logic        w_drive;
    logic        w_regad_ok;
    logic        w_mdio_wr;
    logic [15:0] w_wdata;
    logic [15:0] w_rd_data;

    mdio_edge_sync u_edge_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_mdc      (i_mdc),
        .i_mdio     (i_mdio_in),
        .o_mdc_rise (w_mdc_rise),
        .o_mdio_s   (w_mdio_s)
    );

    // Fields are assembled from the bits already shifted plus the current one.
    assign w_op        = {r_shift[0], w_mdio_s};
    assign w_field5    = {r_shift[3:0], w_mdio_s};
    assign w_phy_match = (w_field5 == PHY_ADDR) ||
                         (BCAST_EN && (w_field5 == BCAST_ADDR) && (r_op == OP_WRITE));
    assign w_drive     = r_match && (r_op == OP_READ);
    assign w_regad_ok  = int'(r_regad) < REG_COUNT;
    assign w_wdata     = {r_shift[14:0], w_mdio_s};
    assign w_mdio_wr   = w_mdc_rise && (r_state == StData) && (r_cnt == 4'(DATA_LEN - 1)) &&
                         r_match && (r_op == OP_WRITE) && w_regad_ok;

    always_comb begin
        w_rd_data = '0;
        if (int'(w_field5) < REG_COUNT) w_rd_data = r_regs[w_field5[AW-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_pre_cnt    <= '0;
            r_shift      <= '0;
            r_op         <= '0;
            r_match      <= 1'b0;
            r_regad      <= '0;
            r_last_regad <= '0;
            r_mdio_oe    <= 1'b0;
            r_mdio_out   <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_rd_strobe  <= 1'b0;
        end else begin
            r_wr_strobe <= w_mdio_wr;
            r_rd_strobe <= 1'b0;
            if (w_mdc_rise) begin
                r_shift <= {r_shift[14:0], w_mdio_s};
                r_cnt   <= r_cnt + 4'd1;
                case (r_state)
                    StIdle: begin
                        r_cnt <= '0;
                        if (w_mdio_s) begin
                            if (r_pre_cnt != PRE_FULL) r_pre_cnt <= r_pre_cnt + 6'd1;
                        end else begin
                            r_pre_cnt <= '0;
                            if (PREAMBLE_SUPPRESS || (r_pre_cnt == PRE_FULL)) r_state <= StStart;
                        end
                    end
                    StStart: begin
                        r_cnt   <= '0;
                        r_state <= w_mdio_s ? StOp : StIdle;
                    end
                    StOp: begin
                        if (r_cnt == 4'(OP_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_op    <= w_op;
                            r_state <= ((w_op == OP_READ) || (w_op == OP_WRITE)) ? StPhyad : StIdle;
                        end
                    end
                    StPhyad: begin
                        // A mismatched frame still walks through the remaining
                        // fields so the bit stream stays aligned.
                        if (r_cnt == 4'(ADDR_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_match <= w_phy_match;
                            r_state <= StRegad;
                        end
                    end
                    StRegad: begin
                        if (r_cnt == 4'(ADDR_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_regad <= w_field5;
                            r_state <= StTa;
                            if (r_match) begin
                                r_last_regad <= w_field5;
                                if (r_op == OP_READ) begin
                                    r_rd_strobe <= 1'b1;
                                    r_shift     <= w_rd_data;
                                end
                            end
                        end
                    end
                    StTa: begin
                        if (r_cnt == 4'd0) begin
                            // Hold the loaded read word; drive the turnaround 0.
                            r_shift <= r_shift;
                            if (w_drive) begin
                                r_mdio_oe  <= 1'b1;
                                r_mdio_out <= 1'b0;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= StData;
                            if (w_drive) r_mdio_out <= r_shift[15];
                        end
                    end
                    StData: begin
                        if (r_cnt == 4'(DATA_LEN - 1)) begin
                            r_cnt      <= '0;
                            r_state    <= StIdle;
                            r_mdio_oe  <= 1'b0;
                            r_mdio_out <= 1'b0;
                        end else if (w_drive) begin
                            r_mdio_out <= r_shift[15];
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    // Register bank: a set reg0[15] wipes everything on the next clk, and an
    // MDIO commit takes priority over a host write to the same register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (r_regs[0][15]) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (w_mdio_wr && (int'(r_regad) == i)) begin
                    r_regs[i] <= w_wdata;
                end else if (i_host_wr_en && (int'(i_host_addr) == i)) begin
                    r_regs[i] <= i_host_wdata;
                end
            end
        end
    end

    always_comb begin
        o_host_rdata = '0;
        if (int'(i_host_addr) < REG_COUNT) o_host_rdata = r_regs[i_host_addr];
    end

    assign o_mdio_out   = r_mdio_out;
    assign o_mdio_oe    = r_mdio_oe;
    assign o_wr_strobe  = r_wr_strobe;
    assign o_rd_strobe  = r_rd_strobe;
    assign o_last_regad = r_last_regad;

endmodule

// File: tb/tb_mdio_peripheral_regfile.sv
// -----------------------------------------------------------------------------
// tb_mdio_peripheral_regfile
// Directed bench: a default instance (full preamble, no broadcast) and a second
// instance with preamble suppression and broadcast writes enabled. sel_ps
// routes the serial stream to one of them; the other sees an idle-high line.
// -----------------------------------------------------------------------------
module tb_mdio_peripheral_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mdc;
    logic        mdio;
    logic        sel_ps;
    logic        host_wr_en;
    logic [4:0]  host_addr;
    logic [15:0] host_wdata;

    logic        m_mdio_in, m_out, m_oe, m_wr, m_rd;
    logic [15:0] m_rdata;
    logic [4:0]  m_last;
    logic        p_mdio_in, p_out, p_oe, p_wr, p_rd;
    logic [15:0] p_rdata;
    logic [4:0]  p_last;

    logic        s_out, s_oe, s_wr, s_rd;
    logic [15:0] s_rdata;

    int total = 0;
    int bad   = 0;
    int wr_cnt, rd_cnt, oe_cycles, off_drive;

    assign m_mdio_in = sel_ps ? 1'b1 : mdio;
    assign p_mdio_in = sel_ps ? mdio : 1'b1;
    assign s_out     = sel_ps ? p_out   : m_out;
    assign s_oe      = sel_ps ? p_oe    : m_oe;
    assign s_wr      = sel_ps ? p_wr    : m_wr;
    assign s_rd      = sel_ps ? p_rd    : m_rd;
    assign s_rdata   = sel_ps ? p_rdata : m_rdata;

    mdio_peripheral_regfile dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mdc        (mdc),
        .i_mdio_in    (m_mdio_in),
        .o_mdio_out   (m_out),
        .o_mdio_oe    (m_oe),
        .i_host_wr_en (host_wr_en),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_rdata (m_rdata),
        .o_wr_strobe  (m_wr),
        .o_rd_strobe  (m_rd),
        .o_last_regad (m_last)
    );

    mdio_peripheral_regfile #(
        .PREAMBLE_SUPPRESS (1'b1),
        .BCAST_EN          (1'b1)
    ) dut_ps (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mdc        (mdc),
        .i_mdio_in    (p_mdio_in),
        .o_mdio_out   (p_out),
        .o_mdio_oe    (p_oe),
        .i_host_wr_en (host_wr_en),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_rdata (p_rdata),
        .o_wr_strobe  (p_wr),
        .o_rd_strobe  (p_rd),
        .o_last_regad (p_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_wr) wr_cnt++;
        if (s_rd) rd_cnt++;
        if (s_oe) oe_cycles++;
        if (!m_oe && m_out) off_drive++;
        if (!p_oe && p_out) off_drive++;
    end

    task automatic clear_counts();
        wr_cnt = 0;
        rd_cnt = 0;
        oe_cycles = 0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mdc period: data set while low, 40 ns low then 40 ns high.
    task automatic mdc_bit(input logic b);
        mdc = 1'b0;
        mdio = b;
        #40;
        mdc = 1'b1;
        #40;
    endtask

    task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                               input logic [4:0] regad);
        for (int i = 0; i < pre; i++) mdc_bit(1'b1);
        mdc_bit(1'b0);
        mdc_bit(1'b1);
        mdc_bit(op[1]);
        mdc_bit(op[0]);
        for (int i = 4; i >= 0; i--) mdc_bit(phy[i]);
        for (int i = 4; i >= 0; i--) mdc_bit(regad[i]);
    endtask

    // With collide set, a host write of reg2 = 16'h1111 is lined up with the
    // clk edge on which the MDIO commit lands (third clk edge after mdc rises).
    task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                               input logic [15:0] data, input bit collide);
        send_header(pre, 2'b01, phy, regad);
        mdc_bit(1'b1);
        mdc_bit(1'b0);
        for (int i = 15; i >= 1; i--) mdc_bit(data[i]);
        mdc = 1'b0;
        mdio = data[0];
        #40;
        mdc = 1'b1;
        if (collide) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            host_wr_en = 1'b1;
            host_addr  = 5'd2;
            host_wdata = 16'h1111;
            @(posedge clk);
            #1;
            total++;
            if (s_wr !== 1'b1) begin
                bad++;
                $display("FAIL collide_align: wr_strobe=%b want 1", s_wr);
            end
            host_wr_en = 1'b0;
            @(negedge clk);
        end
        #40;
    endtask

    // Samples the pad just before each mdc rise from TA bit 2 to data bit 0.
    task automatic read_frame(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                              input logic [15:0] exp, input bit drive, input string name);
        logic [16:0] bits;
        bits = {1'b0, exp};
        send_header(pre, 2'b10, phy, regad);
        mdc_bit(1'b1);
        for (int k = 16; k >= 0; k--) begin
            mdc = 1'b0;
            mdio = 1'b1;
            #39;
            total++;
            if (drive) begin
                if (s_oe !== 1'b1 || s_out !== bits[k]) begin
                    bad++;
                    $display("FAIL %s bit%0d: oe=%b out=%b want oe=1 out=%b",
                             name, k, s_oe, s_out, bits[k]);
                end
            end else if (s_oe !== 1'b0) begin
                bad++;
                $display("FAIL %s bit%0d: oe=%b want 0", name, k, s_oe);
            end
            #1;
            mdc = 1'b1;
            #40;
        end
    endtask

    task automatic host_read(input logic [4:0] a, output logic [15:0] d);
        host_addr = a;
        #1;
        d = s_rdata;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst_n = 1'b0;
        mdc = 1'b1;
        mdio = 1'b1;
        sel_ps = 1'b0;
        host_wr_en = 1'b0;
        host_addr = '0;
        host_wdata = '0;
        clear_counts();
        off_drive = 0;
        wait_clks(3);
        total++;
        if ({m_oe, m_out, m_wr, m_rd} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outs: oe/out/wr/rd=%b want 0000", {m_oe, m_out, m_wr, m_rd});
        end
        total++;
        if (m_last !== 5'd0) begin
            bad++;
            $display("FAIL reset_last: got %0d want 0", m_last);
        end
        rst_n = 1'b1;
        wait_clks(2);
        for (int a = 0; a < 32; a += 31) begin
            host_read(5'(a), d);
            total++;
            if (d !== 16'h0000) begin
                bad++;
                $display("FAIL reset_reg%0d: got %h want 0000", a, d);
            end
        end
    endtask

    task automatic test_write();
        logic [15:0] d;
        wait_clks(2);
        clear_counts();
        write_frame(32, 5'd1, 5'd4, 16'hA5C3, 1'b0);
        wait_clks(4);
        host_read(5'd4, d);
        total++;
        if (d !== 16'hA5C3) begin bad++; $display("FAIL wr_reg4: got %h want a5c3", d); end
        total++;
        if (wr_cnt != 1) begin bad++; $display("FAIL wr_strobes: got %0d want 1", wr_cnt); end
        total++;
        if (oe_cycles != 0) begin bad++; $display("FAIL wr_oe: got %0d want 0", oe_cycles); end
        total++;
        if (m_last !== 5'd4) begin bad++; $display("FAIL wr_last: got %0d want 4", m_last); end
    endtask

    task automatic test_read();
        wait_clks(2);
        clear_counts();
        read_frame(32, 5'd1, 5'd4, 16'hA5C3, 1'b1, "rd4");
        wait_clks(4);
        total++;
        if (oe_cycles != 136) begin bad++; $display("FAIL rd_oe_len: got %0d want 136", oe_cycles); end
        total++;
        if (rd_cnt != 1) begin bad++; $display("FAIL rd_strobes: got %0d want 1", rd_cnt); end
        total++;
        if (wr_cnt != 0) begin bad++; $display("FAIL rd_wr_strobes: got %0d want 0", wr_cnt); end
        total++;
        if (m_oe !== 1'b0) begin bad++; $display("FAIL rd_oe_end: got %b want 0", m_oe); end
    endtask

    task automatic test_reject();
        logic [15:0] d;
        wait_clks(2);
        clear_counts();
        write_frame(32, 5'd3, 5'd5, 16'h1234, 1'b0);
        write_frame(31, 5'd1, 5'd5, 16'h5678, 1'b0);
        read_frame(32, 5'd3, 5'd4, 16'h0000, 1'b0, "rd_phy3");
        wait_clks(4);
        total++;
        if (wr_cnt != 0) begin bad++; $display("FAIL rej_wr: got %0d want 0", wr_cnt); end
        total++;
        if (rd_cnt != 0) begin bad++; $display("FAIL rej_rd: got %0d want 0", rd_cnt); end
        total++;
        if (oe_cycles != 0) begin bad++; $display("FAIL rej_oe: got %0d want 0", oe_cycles); end
        host_read(5'd5, d);
        total++;
        if (d !== 16'h0000) begin bad++; $display("FAIL rej_reg5: got %h want 0000", d); end
        host_read(5'd4, d);
        total++;
        if (d !== 16'hA5C3) begin bad++; $display("FAIL rej_reg4: got %h want a5c3", d); end
    endtask

    task automatic test_collision();
        logic [15:0] d;
        wait_clks(2);
        clear_counts();
        write_frame(32, 5'd1, 5'd2, 16'h2222, 1'b1);
        wait_clks(4);
        host_read(5'd2, d);
        total++;
        if (d !== 16'h2222) begin bad++; $display("FAIL collide_reg2: got %h want 2222", d); end
        wait_clks(1);
        host_wr_en = 1'b1;
        host_addr = 5'd1;
        host_wdata = 16'hBEEF;
        wait_clks(1);
        host_wr_en = 1'b0;
        host_read(5'd1, d);
        total++;
        if (d !== 16'hBEEF) begin bad++; $display("FAIL host_reg1: got %h want beef", d); end
    endtask

    task automatic test_soft_clear();
        logic [15:0] d;
        wait_clks(2);
        clear_counts();
        write_frame(32, 5'd1, 5'd4, 16'h00FF, 1'b0);
        wait_clks(4);
        host_read(5'd4, d);
        total++;
        if (d !== 16'h00FF) begin bad++; $display("FAIL sc_reg4_load: got %h want 00ff", d); end
        wait_clks(1);
        write_frame(32, 5'd1, 5'd0, 16'h8000, 1'b0);
        wait_clks(4);
        for (int a = 0; a < 5; a++) begin
            host_read(5'(a), d);
            total++;
            if (d !== 16'h0000) begin
                bad++;
                $display("FAIL sc_reg%0d: got %h want 0000", a, d);
            end
        end
        total++;
        if (wr_cnt != 2) begin bad++; $display("FAIL sc_wr: got %0d want 2", wr_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] d;
        logic [15:0] w;
        wait_clks(2);
        clear_counts();
        w = 16'hCAFE;
        send_header(32, 2'b01, 5'd1, 5'd6);
        mdc_bit(1'b1);
        mdc_bit(1'b0);
        for (int i = 15; i >= 8; i--) mdc_bit(w[i]);
        rst_n = 1'b0;
        #1;
        total++;
        if (m_oe !== 1'b0) begin bad++; $display("FAIL mid_wr_oe: got %b want 0", m_oe); end
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
        for (int i = 7; i >= 0; i--) mdc_bit(w[i]);
        wait_clks(4);
        host_read(5'd6, d);
        total++;
        if (d !== 16'h0000 || wr_cnt != 0) begin
            bad++;
            $display("FAIL mid_wr_abort: reg6=%h strobes=%0d want 0000/0", d, wr_cnt);
        end
        wait_clks(1);
        write_frame(32, 5'd1, 5'd6, 16'hCAFE, 1'b0);
        wait_clks(4);
        host_read(5'd6, d);
        total++;
        if (d !== 16'hCAFE || wr_cnt != 1) begin
            bad++;
            $display("FAIL mid_wr_next: reg6=%h strobes=%0d want cafe/1", d, wr_cnt);
        end
        // Reset while the peripheral is driving a read.
        wait_clks(2);
        send_header(32, 2'b10, 5'd1, 5'd6);
        for (int i = 0; i < 7; i++) mdc_bit(1'b1);
        total++;
        if (m_oe !== 1'b1) begin bad++; $display("FAIL mid_rd_drive: oe=%b want 1", m_oe); end
        rst_n = 1'b0;
        #1;
        total++;
        if (m_oe !== 1'b0 || m_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_rd_oe: oe=%b out=%b want 0/0", m_oe, m_out);
        end
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
        write_frame(32, 5'd1, 5'd6, 16'h1357, 1'b0);
        wait_clks(2);
        read_frame(32, 5'd1, 5'd6, 16'h1357, 1'b1, "rd6_after_reset");
        wait_clks(4);
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        wait_clks(2);
        sel_ps = 1'b1;
        clear_counts();
        write_frame(0, 5'd1, 5'd7, 16'h0F0F, 1'b0);
        write_frame(0, 5'd0, 5'd8, 16'h3C3C, 1'b0);
        read_frame(0, 5'd1, 5'd7, 16'h0F0F, 1'b1, "ps_rd7");
        wait_clks(4);
        total++;
        if (wr_cnt != 2 || rd_cnt != 1) begin
            bad++;
            $display("FAIL b2b_strobes: wr=%0d rd=%0d want 2/1", wr_cnt, rd_cnt);
        end
        total++;
        if (oe_cycles != 136) begin bad++; $display("FAIL b2b_oe_len: got %0d want 136", oe_cycles); end
        host_read(5'd8, d);
        total++;
        if (d !== 16'h3C3C) begin bad++; $display("FAIL bcast_reg8: got %h want 3c3c", d); end
        total++;
        if (p_last !== 5'd7) begin bad++; $display("FAIL ps_last: got %0d want 7", p_last); end
        wait_clks(1);
        clear_counts();
        read_frame(0, 5'd0, 5'd7, 16'h0000, 1'b0, "ps_bcast_rd");
        wait_clks(4);
        total++;
        if (rd_cnt != 0 || oe_cycles != 0) begin
            bad++;
            $display("FAIL bcast_rd: rd=%0d oe=%0d want 0/0", rd_cnt, oe_cycles);
        end
        sel_ps = 1'b0;
        host_read(5'd7, d);
        total++;
        if (d !== 16'h0000) begin bad++; $display("FAIL main_reg7: got %h want 0000", d); end
        total++;
        if (off_drive != 0) begin
            bad++;
            $display("FAIL out_when_off: got %0d cycles want 0", off_drive);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reject();
        test_collision();
        test_soft_clear();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
